reg_file_sb: RTL

- 8-entry x 8-bit register file with an outstanding-write scoreboard.
- Sits directly downstream of the writeback path: it consumes the selected writeback data, the write enable and the destination register number, and commits the write to architectural state.
- Serves the decode stage with two combinational read ports, with same-cycle writeback bypass.
- Produces a decode stall when an issuing instruction's source operand has an older write still in flight, or when the destination's outstanding-write counter would overflow.

---
 rtl/reg_file_sb_if.sv | 34 +++
 rtl/reg_file_sb.sv | 82 ++++++++
 2 files changed

// File: rtl/reg_file_sb_if.sv
// rtl/reg_file_sb_if.sv - writeback, decode read/issue and debug signals of reg_file_sb
interface reg_file_sb_if #(
    parameter int NREG = 8,
    parameter int DW   = 8
);
    logic [DW-1:0]   WB_mux_out;
    logic            writeRegWB_path;
    logic [2:0]      write_reg_num;
    logic [2:0]      rs_num;
    logic [2:0]      rt_num;
    logic [DW-1:0]   rs_data;
    logic [DW-1:0]   rt_data;
    logic            issue_valid;
    logic            issue_rs_used;
    logic            issue_rt_used;
    logic            issue_wr;
    logic [2:0]      issue_rd;
    logic            stall;
    logic [2:0]      dbg_sel;
    logic [DW-1:0]   dbg_data;
    logic [NREG-1:0] busy;

    modport slave (
        input  WB_mux_out, writeRegWB_path, write_reg_num, rs_num, rt_num,
               issue_valid, issue_rs_used, issue_rt_used, issue_wr, issue_rd, dbg_sel,
        output rs_data, rt_data, stall, dbg_data, busy
    );

    modport master (
        output WB_mux_out, writeRegWB_path, write_reg_num, rs_num, rt_num,
               issue_valid, issue_rs_used, issue_rt_used, issue_wr, issue_rd, dbg_sel,
        input  rs_data, rt_data, stall, dbg_data, busy
    );
endinterface

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - 8x8 register file with writeback bypass and outstanding-write scoreboard
module reg_file_sb #(
    parameter int NREG  = 8,
    parameter int DW    = 8,
    parameter int CNT_W = 2
) (
    input  logic         clk,
    input  logic         reset,
    reg_file_sb_if.slave bus
);
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic [DW-1:0]    regs_q [NREG];
    logic [CNT_W-1:0] cnt_q  [NREG];
    logic [CNT_W-1:0] cnt_d  [NREG];
    logic [DW-1:0]    dbg_q;
    logic [NREG-1:0]  wb_hit;
    logic [NREG-1:0]  pend;
    logic [NREG-1:0]  full;
    logic [NREG-1:0]  inc;
    logic [NREG-1:0]  dec;
    logic [NREG-1:0]  busy;
    logic             stall;

    // A lone in-flight write retiring this cycle is covered by the bypass,
    // and a retiring write frees a counter slot for a new issue.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            wb_hit[r] = bus.writeRegWB_path && (bus.write_reg_num == 3'(r));
            pend[r]   = (cnt_q[r] > CNT_W'(1)) || ((cnt_q[r] == CNT_W'(1)) && !wb_hit[r]);
            full[r]   = (cnt_q[r] == CMAX) && !wb_hit[r];
            busy[r]   = (cnt_q[r] != '0);
        end
    end

    always_comb begin
        stall = bus.issue_valid &&
                ((bus.issue_rs_used && pend[bus.rs_num]) ||
                 (bus.issue_rt_used && pend[bus.rt_num]) ||
                 (bus.issue_wr      && full[bus.issue_rd]));
    end

    // Writes to an untracked register (count 0) never decrement.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            inc[r]   = bus.issue_valid && bus.issue_wr && !stall && (bus.issue_rd == 3'(r));
            dec[r]   = wb_hit[r] && (cnt_q[r] != '0);
            cnt_d[r] = cnt_q[r];
            if (inc[r] && !dec[r]) begin
                cnt_d[r] = cnt_q[r] + CNT_W'(1);
            end else if (dec[r] && !inc[r]) begin
                cnt_d[r] = cnt_q[r] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
                cnt_q[r]  <= '0;
            end
            dbg_q <= '0;
        end else begin
            dbg_q <= regs_q[bus.dbg_sel];
            if (bus.writeRegWB_path) begin
                regs_q[bus.write_reg_num] <= bus.WB_mux_out;
            end
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    assign bus.rs_data  = (bus.writeRegWB_path && (bus.write_reg_num == bus.rs_num)) ?
                          bus.WB_mux_out : regs_q[bus.rs_num];
    assign bus.rt_data  = (bus.writeRegWB_path && (bus.write_reg_num == bus.rt_num)) ?
                          bus.WB_mux_out : regs_q[bus.rt_num];
    assign bus.stall    = stall;
    assign bus.dbg_data = dbg_q;
    assign bus.busy     = busy;
endmodule
